// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: line/address types,
// arbiter state encoding and grant vector bit positions.
package pmem_arbiter_pkg;

   localparam int CACHE_LINE_W = 128;
   localparam int PMEM_ADDR_W  = 16;

   typedef logic [CACHE_LINE_W-1:0] lc3b_cache_line;
   typedef logic [PMEM_ADDR_W-1:0]  lc3b_pmem_addr;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   // One-hot grant vector bit positions
   localparam int GNT_I = 0;
   localparam int GNT_D = 1;

endpackage

// File: rtl/pmem_client_mux.sv
// Steers the granted client's command, address and write line onto the
// memory port. With no grant bit set the port is driven idle (all zero).
module pmem_client_mux
   import pmem_arbiter_pkg::*;
#(
   parameter int LINE_WIDTH = 128,
   parameter int ADDR_WIDTH = 16
) (
   input  logic [1:0]            grant_i,
   input  logic                  i_read_i,
   input  logic                  i_write_i,
   input  logic [ADDR_WIDTH-1:0] i_addr_i,
   input  logic [LINE_WIDTH-1:0] i_wdata_i,
   input  logic                  d_read_i,
   input  logic                  d_write_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [LINE_WIDTH-1:0] d_wdata_i,
   output logic                  read_o,
   output logic                  write_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [LINE_WIDTH-1:0] wdata_o
);

   // Select the granted client; a simultaneous read+write becomes a write
   always_comb begin
      read_o  = 1'b0;
      write_o = 1'b0;
      addr_o  = '0;
      wdata_o = '0;
      if (grant_i[GNT_D]) begin
         read_o  = d_read_i & ~d_write_i;
         write_o = d_write_i;
         addr_o  = d_addr_i;
         wdata_o = d_wdata_i;
      end else if (grant_i[GNT_I]) begin
         read_o  = i_read_i & ~i_write_i;
         write_o = i_write_i;
         addr_o  = i_addr_i;
         wdata_o = i_wdata_i;
      end
   end

endmodule

// File: rtl/pmem_arbiter.sv
// Serialises I-cache and D-cache line requests onto the single physical
// memory port. Round-robin on contention, one transaction in flight, grant
// registered through IDLE, responses steered back only to the owner.
module pmem_arbiter
   import pmem_arbiter_pkg::*;
#(
   parameter int LINE_WIDTH = 128,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_pmem_read,
   input  logic                  i_pmem_write,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
   output logic                  i_pmem_resp,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic                  d_pmem_resp,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic                  arb_busy
);

   arb_state_t state_q, state_d;
   logic       rr_last_q, rr_last_d;   // 0: I served last, 1: D served last
   logic [1:0] grant;
   logic       resp_i, resp_d;
   logic       req_i, req_d;

   assign req_i = i_pmem_read | i_pmem_write;
   assign req_d = d_pmem_read | d_pmem_write;

   // Next-state, round-robin pick, grant and response steering
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      grant     = 2'b00;
      resp_i    = 1'b0;
      resp_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_d && (!req_i || !rr_last_q)) begin
               state_d = SERVE_D;
            end else if (req_i) begin
               state_d = SERVE_I;
            end
         end
         SERVE_I: begin
            // Dropping the request withdraws the command immediately
            grant[GNT_I] = req_i;
            if (pmem_resp) begin
               resp_i    = 1'b1;
               rr_last_d = 1'b0;
               state_d   = IDLE;
            end else if (!req_i) begin
               state_d = IDLE;
            end
         end
         SERVE_D: begin
            grant[GNT_D] = req_d;
            if (pmem_resp) begin
               resp_d    = 1'b1;
               rr_last_d = 1'b1;
               state_d   = IDLE;
            end else if (!req_d) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and round-robin history; reset returns to IDLE with D favoured
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
      end
   end

   pmem_client_mux #(
      .LINE_WIDTH (LINE_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mux (
      .grant_i   (grant),
      .i_read_i  (i_pmem_read),
      .i_write_i (i_pmem_write),
      .i_addr_i  (i_pmem_address),
      .i_wdata_i (i_pmem_wdata),
      .d_read_i  (d_pmem_read),
      .d_write_i (d_pmem_write),
      .d_addr_i  (d_pmem_address),
      .d_wdata_i (d_pmem_wdata),
      .read_o    (pmem_read),
      .write_o   (pmem_write),
      .addr_o    (pmem_address),
      .wdata_o   (pmem_wdata)
   );

   // A transaction cut short by reset never reports completion
   assign i_pmem_resp  = resp_i & ~reset;
   assign d_pmem_resp  = resp_d & ~reset;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign arb_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single-client read, tie-break after
// reset, alternating grants, back-to-back requests, reset mid-transaction,
// abort, read+write priority and a stray memory response.
module tb_pmem_arbiter;

   localparam int LW = 128;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_pmem_read, i_pmem_write, i_pmem_resp;
   logic [AW-1:0] i_pmem_address;
   logic [LW-1:0] i_pmem_wdata, i_pmem_rdata;
   logic          d_pmem_read, d_pmem_write, d_pmem_resp;
   logic [AW-1:0] d_pmem_address;
   logic [LW-1:0] d_pmem_wdata, d_pmem_rdata;
   logic          pmem_read, pmem_write, pmem_resp, arb_busy;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata, pmem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [AW-1:0] A_I  = 16'h0400;
   localparam logic [AW-1:0] A_DR = 16'h1230;
   localparam logic [AW-1:0] A_DW = 16'h2a60;
   localparam logic [LW-1:0] WD_D = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
   localparam logic [LW-1:0] RD_1 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
   localparam logic [LW-1:0] RD_2 = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;

   always #5 clk = ~clk;

   pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_write   (i_pmem_write),
      .i_pmem_address (i_pmem_address),
      .i_pmem_wdata   (i_pmem_wdata),
      .i_pmem_resp    (i_pmem_resp),
      .i_pmem_rdata   (i_pmem_rdata),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_resp    (d_pmem_resp),
      .d_pmem_rdata   (d_pmem_rdata),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp),
      .arb_busy       (arb_busy)
   );

   task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = A_I; i_pmem_wdata = '0;
      d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = A_DR; d_pmem_wdata = WD_D;
      pmem_resp = 0; pmem_rdata = RD_1;
      do_reset();
      settle();
      check_val("rst_busy", LW'(arb_busy), 0);
      check_val("rst_rd", LW'(pmem_read), 0);
      check_val("rst_wr", LW'(pmem_write), 0);
      check_val("rst_addr", LW'(pmem_address), 0);
      check_val("rst_wdata", pmem_wdata, 0);
      check_val("rst_iresp", LW'(i_pmem_resp), 0);
      check_val("rst_dresp", LW'(d_pmem_resp), 0);

      // 1: D-only read, memory answers 3 cycles after the command
      d_pmem_read = 1; d_pmem_address = A_DR;
      settle();
      check_val("t1_idle_rd", LW'(pmem_read), 0);
      step(); settle();
      check_val("t1_rd", LW'(pmem_read), 1);
      check_val("t1_addr", LW'(pmem_address), LW'(A_DR));
      check_val("t1_busy", LW'(arb_busy), 1);
      step(); step(); step();
      pmem_resp = 1; pmem_rdata = RD_1;
      settle();
      check_val("t1_dresp", LW'(d_pmem_resp), 1);
      check_val("t1_iresp", LW'(i_pmem_resp), 0);
      check_val("t1_drdata", d_pmem_rdata, RD_1);
      step();
      pmem_resp = 0; d_pmem_read = 0;
      settle();
      check_val("t1_after_busy", LW'(arb_busy), 0);
      check_val("t1_after_dresp", LW'(d_pmem_resp), 0);

      // 2: simultaneous I read and D write after reset: D first
      do_reset();
      i_pmem_read = 1; i_pmem_address = A_I;
      d_pmem_write = 1; d_pmem_address = A_DW; d_pmem_wdata = WD_D;
      settle();
      step(); settle();
      check_val("t2_d_wr", LW'(pmem_write), 1);
      check_val("t2_d_rd", LW'(pmem_read), 0);
      check_val("t2_d_addr", LW'(pmem_address), LW'(A_DW));
      check_val("t2_d_wdata", pmem_wdata, WD_D);
      pmem_resp = 1;
      settle();
      check_val("t2_dresp", LW'(d_pmem_resp), 1);
      check_val("t2_iresp0", LW'(i_pmem_resp), 0);
      step();
      pmem_resp = 0; d_pmem_write = 0;
      settle();
      check_val("t2_idle_busy", LW'(arb_busy), 0);
      check_val("t2_idle_rd", LW'(pmem_read), 0);
      step(); settle();
      check_val("t2_i_rd", LW'(pmem_read), 1);
      check_val("t2_i_addr", LW'(pmem_address), LW'(A_I));
      pmem_resp = 1; pmem_rdata = RD_2;
      settle();
      check_val("t2_iresp", LW'(i_pmem_resp), 1);
      check_val("t2_irdata", i_pmem_rdata, RD_2);
      check_val("t2_dresp0", LW'(d_pmem_resp), 0);
      step();
      pmem_resp = 0;

      // 3: both held continuously; I served last so order is D, I, D, I
      i_pmem_read = 1; i_pmem_address = A_I;
      d_pmem_read = 1; d_pmem_address = A_DR;
      for (int k = 0; k < 4; k++) begin
         settle();
         check_val($sformatf("t3_idle%0d", k), LW'(arb_busy), 0);
         step(); settle();
         check_val($sformatf("t3_addr%0d", k), LW'(pmem_address),
                   (k % 2 == 0) ? LW'(A_DR) : LW'(A_I));
         pmem_resp = 1;
         settle();
         check_val($sformatf("t3_dresp%0d", k), LW'(d_pmem_resp), (k % 2 == 0) ? 1 : 0);
         check_val($sformatf("t3_iresp%0d", k), LW'(i_pmem_resp), (k % 2 == 0) ? 0 : 1);
         step();
         pmem_resp = 0;
      end
      i_pmem_read = 0; d_pmem_read = 0;
      step();

      // 4: D fill, then D write-back the next cycle while I waits: I wins
      d_pmem_read = 1; d_pmem_address = A_DR;
      step(); settle();
      check_val("t4_dfill_addr", LW'(pmem_address), LW'(A_DR));
      i_pmem_read = 1; i_pmem_address = A_I;
      pmem_resp = 1;
      settle();
      check_val("t4_dfill_resp", LW'(d_pmem_resp), 1);
      step();
      pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 1; d_pmem_address = A_DW;
      settle();
      check_val("t4_idle", LW'(arb_busy), 0);
      step(); settle();
      check_val("t4_i_addr", LW'(pmem_address), LW'(A_I));
      check_val("t4_i_wr", LW'(pmem_write), 0);
      pmem_resp = 1;
      settle();
      check_val("t4_iresp", LW'(i_pmem_resp), 1);
      step();
      pmem_resp = 0; i_pmem_read = 0;
      settle();
      step(); settle();
      check_val("t4_d_wr", LW'(pmem_write), 1);
      check_val("t4_d_addr", LW'(pmem_address), LW'(A_DW));
      pmem_resp = 1;
      settle();
      check_val("t4_dresp", LW'(d_pmem_resp), 1);
      step();
      pmem_resp = 0; d_pmem_write = 0;

      // 5: reset two cycles into SERVE_I, then an abort
      i_pmem_read = 1; i_pmem_address = A_I;
      step();
      settle();
      check_val("t5_serve1", LW'(pmem_read), 1);
      step();
      reset = 1;
      step();
      reset = 0; pmem_resp = 1;
      settle();
      check_val("t5_rst_rd", LW'(pmem_read), 0);
      check_val("t5_rst_busy", LW'(arb_busy), 0);
      check_val("t5_rst_iresp", LW'(i_pmem_resp), 0);
      step();
      pmem_resp = 0; i_pmem_read = 0;
      settle();
      check_val("t5_abort_busy", LW'(arb_busy), 1);
      check_val("t5_abort_rd", LW'(pmem_read), 0);
      step(); settle();
      check_val("t5_abort_idle", LW'(arb_busy), 0);

      // 6: read+write together -> write wins; stray resp in IDLE ignored
      d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = A_DW; d_pmem_wdata = WD_D;
      step(); settle();
      check_val("t6_wr", LW'(pmem_write), 1);
      check_val("t6_rd", LW'(pmem_read), 0);
      pmem_resp = 1;
      settle();
      check_val("t6_dresp", LW'(d_pmem_resp), 1);
      step();
      pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;
      step();
      pmem_resp = 1;
      settle();
      check_val("t6_stray_iresp", LW'(i_pmem_resp), 0);
      check_val("t6_stray_dresp", LW'(d_pmem_resp), 0);
      step();
      pmem_resp = 0;
      settle();
      check_val("t6_stray_busy", LW'(arb_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits directly downstream of the instruction-cache and data-cache controllers, upstream of the single physical-memory port.
- Each cache controller holds its pmem_read/pmem_write level until it sees pmem_resp; this block serialises those line-sized requests onto one memory port.
- It routes the response back to the requester only.
- Round-robin on contention; one transaction outstanding at a time.

Parameters:
- LINE_WIDTH, 128, cache line width in bits (8 words of 16 bits).
- ADDR_WIDTH, 16, physical byte address width; low 4 bits are always 0 for line transfers.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp.
- i_pmem_write  in  1  I-cache line write request; tied 0 in current design but fully supported.
- i_pmem_address  in  ADDR_WIDTH  I-cache line address.
- i_pmem_wdata  in  LINE_WIDTH  I-cache write line.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- i_pmem_rdata  out  LINE_WIDTH  read line to I-cache.
- d_pmem_read  in  1  D-cache line read request (fill).
- d_pmem_write  in  1  D-cache line write request (dirty write-back).
- d_pmem_address  in  ADDR_WIDTH  D-cache line address.
- d_pmem_wdata  in  LINE_WIDTH  D-cache write line.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- d_pmem_rdata  out  LINE_WIDTH  read line to D-cache.
- pmem_read  out  1  read command to physical memory.
- pmem_write  out  1  write command to physical memory.
- pmem_address  out  ADDR_WIDTH  address to memory.
- pmem_wdata  out  LINE_WIDTH  write line to memory.
- pmem_rdata  in  LINE_WIDTH  read line from memory, valid with pmem_resp.
- pmem_resp  in  1  one-cycle memory completion pulse.
- arb_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on port reset; sampled only at the rising edge of clk.
- State register:
  - States: IDLE, SERVE_I, SERVE_D.
  - rr_last, 1 bit: 0 = I last served, 1 = D last served.
- Reset values:
  - state = IDLE, rr_last = 0 (D wins the first tie).
  - All command and resp outputs are 0.
  - pmem_address and pmem_wdata are 0 in IDLE.
- Request definitions:
  - req_i = i_pmem_read | i_pmem_write.
  - req_d = d_pmem_read | d_pmem_write.
- IDLE:
  - No memory command is driven.
  - Only req_d -> SERVE_D.
  - Only req_i -> SERVE_I.
  - Both -> SERVE_D if rr_last = 0, else SERVE_I.
  - Neither -> stay in IDLE.
  - Grant is registered: there is exactly one IDLE cycle between a request rising and the memory command.
- SERVE_x:
  - pmem_address and pmem_wdata are combinationally muxed from client x.
  - pmem_read = x_pmem_read & ~x_pmem_write; pmem_write = x_pmem_write.
  - If a client asserts read and write together, write wins.
- Completion:
  - On pmem_resp in SERVE_x: x_pmem_resp = 1 for that cycle only, the other client's resp = 0, rr_last updates to x, next state = IDLE.
  - pmem_resp received in IDLE is ignored: no client resp, no state change.
- Abort:
  - If client x drops its request while in SERVE_x without pmem_resp, return to IDLE next cycle and drive no command in that cycle.
  - rr_last is not updated.
  - A pmem_resp arriving in that same cycle is still forwarded to x.
- Read data: pmem_rdata is broadcast unregistered to both i_pmem_rdata and d_pmem_rdata. Clients qualify it with their own resp.
- Back-to-back requests:
  - A client that issues a new request the cycle after its resp, such as D-cache fill followed by write-back, goes through IDLE arbitration again.
  - If the other client is waiting, it wins.
- Latency: a request accepted in IDLE at cycle t drives its memory command from t+1. Client resp is in the same cycle as pmem_resp (zero added response latency).
- Reset mid-transaction: the next state is IDLE, all outputs drop the next cycle, rr_last returns to 0, and no resp is generated.
- No starvation: with both clients continuously requesting, grants strictly alternate.

Decomposition:
- lc3b_types gains:
  - lc3b_cache_line (logic [127:0]).
  - lc3b_pmem_addr, if not already present.
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}.
- Sub-module pmem_client_mux: combinational select of address, wdata and read/write, driven by the one-hot grant. The FSM, rr_last and resp steering stay in pmem_arbiter.

Test Plan:
1. D-only read of 0x1230, memory resp 3 cycles after pmem_read -> pmem_read rises 1 cycle after d_pmem_read with pmem_address = 0x1230. d_pmem_resp pulses with pmem_resp, d_pmem_rdata = memory line. i_pmem_resp stays 0.
2. i_pmem_read (0x0400) and d_pmem_write (0x2a60, wdata 0xDEAD...BEEF) rise together after reset -> D served first with pmem_write = 1 and wdata matching, then IDLE, then I read at 0x0400. rr_last = 0 (I last served) at the end.
3. Both clients requesting continuously for 4 transactions -> grant order D, I, D, I. Exactly one IDLE cycle between each.
4. D-cache fill resp followed next cycle by d_pmem_write while i_pmem_read is pending -> I granted before the D write-back.
5. Reset asserted 2 cycles into SERVE_I -> next cycle pmem_read = 0, state IDLE, and no i_pmem_resp even if pmem_resp arrives that cycle.
6. d_pmem_read and d_pmem_write both high -> pmem_write = 1, pmem_read = 0. Separately, a stray pmem_resp in IDLE -> no client resp.
